branch_cmp_pipe: RTL
====================

# branch_cmp_pipe

Registered, parametrised branch-condition unit for the pipelined CPU's decode/branch path. It evaluates equality, unsigned, signed and compare-with-zero conditions on two WIDTH-bit operands. The verdict is held in a one-entry output stage with a valid/ready handshake and a flush. It also keeps saturating counters of resolved and taken branches for performance monitoring.

## Interface
- WIDTH, 32, operand width (≥2)
- CNT_W, 16, width of both performance counters (≥1)

- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- in_valid  input  1  operands/op presented this cycle
- in_ready  output  1  unit can accept (combinational)
- a  input  WIDTH  first operand (rs value)
- b  input  WIDTH  second operand (rt value; ignored for zero compares)
- op  input  4  condition code, see Operation
- flush  input  1  discard held result and any same-cycle capture
- out_valid  output  1  registered verdict available
- out_ready  input  1  consumer takes verdict this cycle
- taken  output  1  registered verdict (1 = branch taken)
- illegal  output  1  registered: captured op was 14 or 15
- branch_cnt  output  CNT_W  legal verdicts delivered, saturating
- taken_cnt  output  CNT_W  taken verdicts delivered, saturating

## Operation
- Op encoding:
  - 0: a==b
  - 1: a>=b (unsigned)
  - 2: a>b (unsigned)
  - 3: a<=b (unsigned)
  - 4: a<b (unsigned)
  - 5: a!=b
  - 6–9: as 1–4 but two's-complement signed
  - 10: a>=0 (signed)
  - 11: a>0
  - 12: a<=0
  - 13: a<0
  - 14, 15: illegal, which gives taken=0 and illegal=1
- Arithmetic:
  - Signed compares use the full WIDTH-bit two's-complement value, so MSB=1 is negative.
  - Unsigned compares treat both operands as WIDTH-bit naturals.
  - There is no extension and no truncation.
- Output stage is one entry; states are EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready. A new capture is permitted in the same cycle the held verdict is consumed.
- Capture condition: in_valid && in_ready && !flush. On capture, taken and illegal load the combinational verdict and out_valid goes to 1.
- EMPTY→FULL on capture.
- FULL→EMPTY on out_ready with no capture.
- FULL→FULL on out_ready with capture (new verdict loaded).
- FULL with !out_ready holds: taken and illegal stable, in_ready=0.
- Flush:
  - Next cycle out_valid=0.
  - A same-cycle capture is suppressed.
  - A same-cycle out_ready handshake still counts as delivered, because the consumer took it.
  - Flush has priority over capture. in_ready is unaffected by flush.
- Counters:
  - On a delivery (out_valid && out_ready) with illegal=0, branch_cnt increments.
  - taken_cnt also increments if taken=1.
  - Illegal deliveries count in neither counter.
  - Each counter saturates at 2^CNT_W−1 and never wraps.
- taken and illegal hold their last values while EMPTY. Consumers use them only when out_valid=1.

## Timing
- Reset value of every output:
  - out_valid=0, taken=0, illegal=0, branch_cnt=0, taken_cnt=0.
  - in_ready=1 in the first cycle after reset.
- Reset asserted mid-operation drops the held verdict without counting it, even if out_ready=1 that cycle.
- Latency: a verdict captured at edge N is visible with out_valid=1 after edge N. That is one cycle from in_valid to out_valid.
- Throughput: one verdict per cycle while out_ready=1.
- Counters update on the edge that completes the delivery and are visible the following cycle.
- No combinational path from a, b or op to any output. in_ready depends only on out_valid and out_ready.

## Test plan
- Reset, then WIDTH=32, op=6, a=0xFFFFFFFF, b=0x00000001, out_ready=1 → next cycle out_valid=1, taken=0. Same operands with op=1 → taken=1.
- Stream ops 10–13 with a=0 → taken = 1,0,1,0 on consecutive cycles. Then op=14 → illegal=1, taken=0, and branch_cnt=4 after the last delivery.
- Capture op=0 with a=b=5 and out_ready=0 for 3 cycles → out_valid=1, taken=1 held stable, in_ready=0 throughout. Then out_ready=1 with new in_valid the same cycle → back-to-back capture, and branch_cnt increments by 1.
- FULL with out_ready=0, then flush=1 together with in_valid=1 → next cycle out_valid=0 and counters unchanged. Repeat with out_ready=1 → counters increment by 1 and out_valid=0 next cycle.
- CNT_W=2, deliver 5 taken verdicts → branch_cnt=3 and taken_cnt=3 (saturated, no wrap).
- Reset asserted for one cycle while FULL with out_ready=1 → next cycle every output is 0 except in_ready=1, and counters read 0.

Source files
------------

// File: rtl/branch_cmp_pipe.sv
// Registered branch-condition unit: evaluates an equality/unsigned/signed/zero compare,
// holds the verdict in a one-entry valid/ready stage, and counts delivered branches.
module branch_cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    logic   eq, ult, slt, a_zero, a_neg;
    logic   v_taken, v_illegal;
    logic   capture, deliver;

    assign eq     = (a == b);
    assign ult    = (a < b);
    assign slt    = ($signed(a) < $signed(b));
    assign a_zero = (a == '0);
    assign a_neg  = a[WIDTH-1];

    // Every condition is derived from three primitive compares plus the sign/zero of a.
    always_comb begin
        v_taken   = 1'b0;
        v_illegal = 1'b0;
        case (op)
            4'd0:    v_taken = eq;
            4'd1:    v_taken = !ult;
            4'd2:    v_taken = !ult && !eq;
            4'd3:    v_taken = ult || eq;
            4'd4:    v_taken = ult;
            4'd5:    v_taken = !eq;
            4'd6:    v_taken = !slt;
            4'd7:    v_taken = !slt && !eq;
            4'd8:    v_taken = slt || eq;
            4'd9:    v_taken = slt;
            4'd10:   v_taken = !a_neg;
            4'd11:   v_taken = !a_neg && !a_zero;
            4'd12:   v_taken = a_neg || a_zero;
            4'd13:   v_taken = a_neg;
            default: v_illegal = 1'b1;
        endcase
    end

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign capture   = in_valid && in_ready && !flush;
    assign deliver   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            taken      <= 1'b0;
            illegal    <= 1'b0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            // A delivery counts even when flush drops the stage in the same cycle.
            if (deliver && !illegal) begin
                if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 1'b1;
                if (taken && taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + 1'b1;
            end
            if (capture) begin
                state   <= FULL;
                taken   <= v_taken;
                illegal <= v_illegal;
            end else if (flush || deliver) begin
                state <= EMPTY;
            end
        end
    end

endmodule
